// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch port and the data port. Requests are serialised, data
// wins ties, and a streak counter forces an IF grant after MAX_D_STREAK
// consecutive data grants made while a fetch was waiting.
package mem_arbiter_pkg;
    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd4,
        MEM_LHU = 3'd5
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;
endpackage

// Handshakes:
//  - Requester side: a requester raises *_req with its fields stable and
//    keeps them until the matching *_valid pulse (exactly one cycle). During
//    that pulse cycle requests are ignored, so the requester may drop the
//    request or present a new one at once.
//  - Memory side: m_req and its fields stay stable until the cycle in which
//    m_gnt=1 (transfer happens on that edge). m_rvalid arrives at least one
//    cycle later and is only accepted while waiting for it; m_gnt/m_rvalid
//    seen in any other state are ignored.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_wr_en,
    input  mem_op_t           d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall,
    output logic              m_req,
    output logic              m_wr_en,
    output mem_op_t           m_op,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output arb_state_t        dbg_state,
    output logic [3:0]        dbg_d_streak
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    arb_state_t state;
    logic       owner_d;   // 1 = data port owns the current transaction
    logic [3:0] d_streak;  // data grants made while a fetch was pending

    // Data wins unless a waiting fetch has already been passed over MAX times.
    logic grant_d;
    logic grant_if;
    assign grant_d  = d_req && (!if_req || (d_streak != MAX_STREAK));
    assign grant_if = if_req && !grant_d;

    // Pipeline stall while either requester is still waiting for its response.
    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    assign dbg_state    = state;
    assign dbg_d_streak = d_streak;

    // Arbitration FSM: owns all memory-side and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            owner_d  <= 1'b0;
            d_streak <= 4'd0;
            m_req    <= 1'b0;
            m_wr_en  <= 1'b0;
            m_op     <= MEM_LB;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner_d <= 1'b1;
                        m_req   <= 1'b1;
                        m_wr_en <= d_wr_en;
                        m_op    <= d_op;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        state   <= ST_REQ;
                        if (if_req) begin
                            if (d_streak != 4'd15) begin
                                d_streak <= d_streak + 4'd1;
                            end
                        end else begin
                            d_streak <= 4'd0;
                        end
                    end else if (grant_if) begin
                        owner_d  <= 1'b0;
                        m_req    <= 1'b1;
                        m_wr_en  <= 1'b0;
                        m_op     <= MEM_LW;
                        m_addr   <= if_addr;
                        m_wdata  <= '0;
                        d_streak <= 4'd0;
                        state    <= ST_REQ;
                    end else begin
                        d_streak <= 4'd0;
                    end
                end
                ST_REQ: begin
                    if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid) begin
                        if (owner_d) begin
                            d_rdata <= m_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= m_rdata;
                            if_valid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and a randomized memory model around
// mem_arbiter. Expected read data is a fixed function of the address, so the
// per-port expected queues are independent of arbitration order; grants are
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAX_D = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_wr_en;
    mem_op_t     d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall;
    logic        m_req;
    logic        m_wr_en;
    mem_op_t     m_op;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    arb_state_t  dbg_state;
    logic [3:0]  dbg_d_streak;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX_D)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_wr_en(d_wr_en), .d_op(d_op), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
        .m_req(m_req), .m_wr_en(m_wr_en), .m_op(m_op), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .dbg_state(dbg_state), .dbg_d_streak(dbg_d_streak)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] if_exp_q[$];
    logic [31:0] d_exp_q[$];

    mem_op_t ops [5] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};

    // Memory model configuration (written by the main sequence only).
    int gnt_max    = 0;
    int rv_min     = 0;
    int rv_max     = 0;
    bit spur_en    = 1'b0;
    bit force_spur = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00500093 ^ (a * 32'h9E3779B1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition violated t=%0t", name, $time);
    endtask

    // Driver tasks: hold a request until its valid, then drop or re-raise.
    task automatic if_drive(input int n, input int gap_max);
        int gap;
        bit got;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(gap_max, 0));
            if (gap > 0) begin
                if_req = 1'b0;
                repeat (gap) @(negedge clk);
            end
            if_addr = $urandom_range(1023, 0) << 2;
            if_req  = 1'b1;
            if_exp_q.push_back(mem_word(if_addr));
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (if_valid) got = 1'b1;
            end
            if (!got) begin
                note_fail("if_timeout");
                void'(if_exp_q.pop_back());
            end
        end
        if_req = 1'b0;
    endtask

    task automatic d_drive(input int n, input int gap_max);
        int gap;
        bit got;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(gap_max, 0));
            if (gap > 0) begin
                d_req = 1'b0;
                repeat (gap) @(negedge clk);
            end
            d_addr  = 32'h1000 | ($urandom_range(1023, 0) << 2);
            d_wr_en = 1'($urandom_range(1, 0));
            d_op    = ops[$urandom_range(4, 0)];
            d_wdata = $urandom();
            d_req   = 1'b1;
            d_exp_q.push_back(mem_word(d_addr));
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (d_valid) got = 1'b1;
            end
            if (!got) begin
                note_fail("d_timeout");
                void'(d_exp_q.pop_back());
            end
        end
        d_req = 1'b0;
    endtask

    // Memory model: random grant delay, random response latency, optional
    // spurious m_gnt/m_rvalid while no transaction is outstanding.
    int          mst = 0;
    int          gd;
    int          rd;
    bit          fresh;
    bit          spur_done = 1'b0;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_wr;
    mem_op_t     lat_op;

    initial begin
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_gnt    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = $urandom();
            if (mst == 0 && m_req && resetn) begin
                lat_addr  = m_addr;
                lat_wdata = m_wdata;
                lat_wr    = m_wr_en;
                lat_op    = m_op;
                gd        = int'($urandom_range(gnt_max, 0));
                fresh     = 1'b1;
                mst       = 1;
            end
            if (mst == 1) begin
                if (!fresh) begin
                    check("m_req_held", 32'(m_req), 32'd1);
                    check("m_addr_stable", m_addr, lat_addr);
                    check("m_wdata_stable", m_wdata, lat_wdata);
                    check("m_wr_en_stable", 32'(m_wr_en), 32'(lat_wr));
                    check("m_op_stable", 32'(m_op), 32'(lat_op));
                end
                fresh = 1'b0;
                if (gd == 0) begin
                    m_gnt = 1'b1;
                    rd    = int'($urandom_range(rv_max, rv_min));
                    mst   = 2;
                end else begin
                    gd--;
                end
            end else if (mst == 2) begin
                check("m_req_dropped", 32'(m_req), 32'd0);
                if (rd == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = mem_word(lat_addr);
                    mst      = 0;
                end else begin
                    rd--;
                end
            end else if (force_spur && !spur_done) begin
                m_rvalid  = 1'b1;
                m_rdata   = 32'h12345678;
                spur_done = 1'b1;
            end else if (spur_en && $urandom_range(7, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) m_rvalid = 1'b1;
                else m_gnt = 1'b1;
            end
        end
    end

    // Scoreboard monitor: response data, held rdata, stall, grant decisions.
    logic        p_if = 1'b0;
    logic        p_d = 1'b0;
    logic        p_mreq = 1'b0;
    logic [31:0] p_if_addr;
    logic [31:0] p_d_addr;
    logic [31:0] p_d_wdata;
    logic        p_d_wr;
    mem_op_t     p_d_op;
    int          streak_m = 0;
    logic [31:0] hold_if = '0;
    logic [31:0] hold_d = '0;
    bit          win_d;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                hold_if  = '0;
                hold_d   = '0;
                streak_m = 0;
            end else begin
                check("stall", 32'(stall), 32'((if_req && !if_valid) || (d_req && !d_valid)));
                if (if_valid && d_valid) note_fail("both_valid");
                if (if_valid) begin
                    if (if_exp_q.size() == 0) note_fail("if_valid_unexpected");
                    else hold_if = if_exp_q.pop_front();
                end
                if (d_valid) begin
                    if (d_exp_q.size() == 0) note_fail("d_valid_unexpected");
                    else hold_d = d_exp_q.pop_front();
                end
                check("if_rdata", if_rdata, hold_if);
                check("d_rdata", d_rdata, hold_d);
                if (m_req && !p_mreq) begin
                    if (!p_if && !p_d) begin
                        note_fail("grant_without_request");
                    end else begin
                        win_d = (p_if && p_d) ? (streak_m < MAX_D) : p_d;
                        if (win_d) begin
                            check("grant_d_addr", m_addr, p_d_addr);
                            check("grant_d_wr_en", 32'(m_wr_en), 32'(p_d_wr));
                            check("grant_d_op", 32'(m_op), 32'(p_d_op));
                            check("grant_d_wdata", m_wdata, p_d_wdata);
                            streak_m = p_if ? streak_m + 1 : 0;
                        end else begin
                            check("grant_if_addr", m_addr, p_if_addr);
                            check("grant_if_wr_en", 32'(m_wr_en), 32'd0);
                            check("grant_if_op", 32'(m_op), 32'(MEM_LW));
                            check("grant_if_wdata", m_wdata, 32'd0);
                            streak_m = 0;
                        end
                        check("d_streak", 32'(dbg_d_streak), 32'(streak_m));
                    end
                end
            end
            p_if      = if_req;
            p_d       = d_req;
            p_mreq    = m_req;
            p_if_addr = if_addr;
            p_d_addr  = d_addr;
            p_d_wdata = d_wdata;
            p_d_wr    = d_wr_en;
            p_d_op    = d_op;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"}, 32'(m_req), 32'd0);
        check({tag, "_m_wr_en"}, 32'(m_wr_en), 32'd0);
        check({tag, "_m_op"}, 32'(m_op), 32'd0);
        check({tag, "_m_addr"}, m_addr, 32'd0);
        check({tag, "_m_wdata"}, m_wdata, 32'd0);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_d_streak"}, 32'(dbg_d_streak), 32'd0);
    endtask

    // Main sequence
    initial begin
        bit reached;
        resetn  = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_wr_en = 1'b0;
        d_op    = MEM_LB;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        check("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Minimum-latency fetch: valid exactly three cycles after req.
        if_addr = 32'h0;
        if_req  = 1'b1;
        if_exp_q.push_back(mem_word(32'h0));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            check("lat_if_valid", 32'(if_valid), 32'(k == 3));
            check("lat_stall", 32'(stall), 32'(k != 3));
            if (k == 1) check("lat_m_req", 32'(m_req), 32'd1);
        end
        check("lat_if_rdata", if_rdata, 32'h00500093);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious m_rvalid while idle must not disturb anything.
        force_spur = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("spur_if_rdata", if_rdata, 32'h00500093);
        check("spur_d_rdata", d_rdata, 32'd0);
        check("spur_state", 32'(dbg_state), 32'(ST_IDLE));

        // Randomized mixed traffic with variable grant and response delays.
        gnt_max = 3;
        rv_min  = 0;
        rv_max  = 3;
        spur_en = 1'b1;
        fork
            if_drive(40, 3);
            d_drive(60, 2);
        join

        // Saturated traffic: both ports re-request immediately.
        fork
            if_drive(10, 0);
            d_drive(60, 0);
        join

        // Reset while waiting for the response; the late m_rvalid is dropped.
        spur_en = 1'b0;
        gnt_max = 0;
        rv_min  = 6;
        rv_max  = 6;
        repeat (2) @(negedge clk);
        if_addr = 32'h40;
        if_req  = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT) reached = 1'b1;
        end
        if (!reached) note_fail("reach_wait");
        resetn = 1'b0;
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("wait_reset");
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check_all_zero("late_rvalid");

        gnt_max = 2;
        rv_min  = 0;
        rv_max  = 2;
        if_drive(3, 1);
        repeat (4) @(negedge clk);
        check("if_queue_empty", 32'(if_exp_q.size()), 32'd0);
        check("d_queue_empty", 32'(d_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Final report if the run stalls.
    initial begin
        #500000;
        note_fail("watchdog");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency backing memory between the CPU instruction-fetch port and the data (MEM-stage) port.
- Sits between the cpu and the unified memory model.
- Serialises requests, with data priority and an instruction-fetch anti-starvation limit.
- Drives a pipeline stall while either requester is waiting.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while if_req pends before IF is forced (legal range 1..15).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid with if_valid, held until next IF response.
- if_valid  out  1  one-cycle response pulse for the IF port.
- d_req  in  1  data request; held high with its fields stable until d_valid.
- d_wr_en  in  1  1 = store, 0 = load.
- d_op  in  mem_op_t  access size/sign, passed to memory.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid with d_valid, held until next data response.
- d_valid  out  1  one-cycle response pulse for the data port (also pulses for stores).
- stall  out  1  (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
- m_req  out  1  memory request, registered.
- m_wr_en  out  1  registered copy of winner's write enable (0 for IF).
- m_op  out  mem_op_t  registered; IF uses the word-load encoding.
- m_addr  out  ADDR_W  registered winner address.
- m_wdata  out  DATA_W  registered winner store data (0 for IF).
- m_gnt  in  1  memory accepts the request this cycle.
- m_rvalid  in  1  read data valid or write acknowledge; arrives at least 1 cycle after the m_gnt cycle.
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; all registered outputs 0 (m_req, m_wr_en, m_op, m_addr, m_wdata, if_valid, d_valid, if_rdata, d_rdata); d_streak=0.
  - An in-flight memory transaction is abandoned. A late m_rvalid after reset is ignored because state is IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester active: grant it.
  - Both active: grant data unless d_streak == MAX_D_STREAK, in which case grant IF.
  - On grant: latch owner, load m_* registers from the winner, set m_req=1, go to REQ.
- d_streak:
  - Increments on a data grant while if_req=1 (saturating at 15).
  - Clears on any IF grant, or in any IDLE cycle with if_req=0.
- REQ: m_req held with fields stable until m_gnt=1. Then m_req=0 next cycle, go to WAIT.
- WAIT: on m_rvalid=1, capture m_rdata into the owner's rdata register, set the owner's valid=1 next cycle, go to RESP. For stores, d_rdata is still updated with m_rdata.
- RESP: owner's valid high for exactly this cycle. Both if_req and d_req are ignored this cycle. Go to IDLE. The requester must drop or change its request by the following cycle.
- Timing:
  - Minimum latency, req rising (cycle 0) → valid: m_req in cycle 1, m_gnt in cycle 1, m_rvalid in cycle 2, valid in cycle 3. That is 3 cycles, with a new grant possible in cycle 4.
  - Back-to-back throughput is therefore 1 access per 4 cycles minimum.
- Spurious m_rvalid in IDLE, REQ or RESP is ignored; state and outputs are unchanged.
- m_gnt outside REQ is ignored.
- Requests raised during REQ/WAIT/RESP are only arbitrated in the next IDLE.
- if_valid and d_valid are never high in the same cycle. At most one transaction is outstanding.

Test Plan:
- Reset release, if_req=1, if_addr=0x0, memory returns m_rdata=0x00500093 with gnt in cycle 1 and rvalid in cycle 2 → if_valid in cycle 3 with if_rdata=0x00500093; stall=1 in cycles 0-2 and 0 in cycle 3.
- Both req high in the same cycle, d_addr=0x100 load, if_addr=0x4 → data served first (m_addr=0x100, d_valid), then IF (m_addr=0x4, if_valid); stall stays high until if_valid.
- Store: d_wr_en=1, d_addr=0x200, d_wdata=0xDEADBEEF, memory delays gnt 3 cycles → m_req and fields held stable 3 cycles; d_valid pulses once after the ack; m_wr_en=1 only in the data transaction.
- Starvation: if_req held high, d_req re-raised immediately after every d_valid, MAX_D_STREAK=4 → exactly 4 data grants, then an IF grant, then d_streak=0 and data wins again.
- Reset asserted in WAIT (after gnt, before rvalid), released, then m_rvalid=1 arrives → all outputs 0, no valid pulse, state IDLE; the next if_req is served normally.
- Spurious m_rvalid=1 in IDLE with m_rdata=0x12345678 → if_rdata and d_rdata unchanged, no valid pulse.
